// File: rtl/pdu_debug_ctrl_if.sv
// rtl/pdu_debug_ctrl_if.sv - debug-word read request/response channel between display path and debug controller
//
// Purpose: carries one debug-word read at a time. The requester pulses chk_req with a
//          selector on chk_sel. The controller answers with either a chk_valid pulse and
//          the captured word on chk_data, or a chk_err pulse when the CPU is not halted.
// Signals:
//   chk_req    requester -> controller  1-cycle read request
//   chk_sel    requester -> controller  debug selector, sampled on an accepted request
//   chk_data   controller -> requester  last captured debug word
//   chk_valid  controller -> requester  1-cycle pulse, chk_data updated
//   chk_err    controller -> requester  1-cycle pulse, request rejected (CPU running)
interface pdu_debug_ctrl_if;
    logic        chk_req;
    logic [31:0] chk_sel;
    logic [31:0] chk_data;
    logic        chk_valid;
    logic        chk_err;

    modport master (
        output chk_req,
        output chk_sel,
        input  chk_data,
        input  chk_valid,
        input  chk_err
    );

    modport slave (
        input  chk_req,
        input  chk_sel,
        output chk_data,
        output chk_valid,
        output chk_err
    );
endinterface

// File: rtl/pdu_debug_ctrl.sv
// rtl/pdu_debug_ctrl.sv - PDU debug-bus master: CPU clock gating, run/step/breakpoint control, debug word capture
//
// Purpose: gates the CPU clock (o_cpu_clk_en) to implement halt, free-run, single-step
//          and PC breakpoint modes, and reads datapath debug words over the CPU debug bus
//          while the CPU is halted.
// Parameters:
//   SYNC_STAGES  synchroniser depth on i_run_sw / i_step_btn (must be >= 2)
//   CHK_WAIT     settle cycles between driving o_cpu_check_addr and sampling i_cpu_check_data
//   CNT_W        width of the retired-instruction counter
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_run_sw           async level, 1 = free-run request
//   i_step_btn         async level, each rising edge = one-instruction request
//   i_bp_en, i_bp_addr breakpoint enable and PC
//   i_current_pc       CPU current PC
//   i_next_pc          CPU next PC, passed to the display path on o_disp_next_pc
//   i_cpu_check_data   CPU debug read data
//   chk_if             debug-word read channel (slave side)
//   o_cpu_check_addr   debug selector driven to the CPU, holds outside reads
//   o_cpu_clk_en       1 = CPU executes one instruction on this clk edge
//   o_halted           1 in HALT or READ
//   o_bp_hit           sticky breakpoint-stop flag, cleared when execution resumes
//   o_inst_cnt         count of cycles with o_cpu_clk_en = 1, wrapping
//   o_disp_next_pc     next PC exported for display
module pdu_debug_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CHK_WAIT    = 1,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run_sw,
    input  logic              i_step_btn,
    input  logic              i_bp_en,
    input  logic [31:0]       i_bp_addr,
    input  logic [31:0]       i_current_pc,
    input  logic [31:0]       i_next_pc,
    input  logic [31:0]       i_cpu_check_data,
    pdu_debug_ctrl_if.slave   chk_if,
    output logic [31:0]       o_cpu_check_addr,
    output logic              o_cpu_clk_en,
    output logic              o_halted,
    output logic              o_bp_hit,
    output logic [CNT_W-1:0]  o_inst_cnt,
    output logic [31:0]       o_disp_next_pc
);

    localparam int RD_W = (CHK_WAIT > 0) ? $clog2(CHK_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_READ = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_run_sync;
    logic [SYNC_STAGES-1:0] r_step_sync;
    logic                   r_step_s_d;
    logic                   r_bp_skip;
    logic                   r_bp_hit;
    logic [RD_W-1:0]        r_rd_cnt;
    logic [31:0]            r_chk_addr;
    logic [31:0]            r_chk_data;
    logic                   r_chk_valid;
    logic                   r_chk_err;
    logic [CNT_W-1:0]       r_inst_cnt;

    logic                   w_run_s;
    logic                   w_step_s;
    logic                   w_step_rise;
    logic                   w_pc_match;
    logic                   w_bp_stop;
    logic                   w_cpu_clk_en;
    logic                   w_read_done;

    assign w_run_s     = r_run_sync[SYNC_STAGES-1];
    assign w_step_s    = r_step_sync[SYNC_STAGES-1];
    assign w_step_rise = w_step_s & ~r_step_s_d;
    assign w_pc_match  = (i_current_pc == i_bp_addr);
    // bp_skip lets the instruction sitting on the breakpoint execute once after a resume.
    assign w_bp_stop   = i_bp_en & w_pc_match & ~r_bp_skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_clk_en = 1'b0;
        w_read_done  = 1'b0;
        case (r_state)
            S_HALT: begin
                if (chk_if.chk_req) begin
                    w_state_nxt = S_READ;
                end else if (w_run_s) begin
                    w_state_nxt = S_RUN;
                end else if (w_step_rise) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                // On a breakpoint stop the CPU clock is held off so the instruction at
                // bp_addr is not executed.
                w_cpu_clk_en = ~w_bp_stop;
                if (!w_run_s || w_bp_stop) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_STEP: begin
                w_cpu_clk_en = 1'b1;
                w_state_nxt  = S_HALT;
            end
            S_READ: begin
                if (r_rd_cnt == RD_W'(CHK_WAIT)) begin
                    w_read_done = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_sync  <= '0;
            r_step_sync <= '0;
            r_step_s_d  <= 1'b0;
            r_bp_skip   <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_rd_cnt    <= '0;
            r_chk_addr  <= '0;
            r_chk_data  <= '0;
            r_chk_valid <= 1'b0;
            r_chk_err   <= 1'b0;
            r_inst_cnt  <= '0;
        end else begin
            r_run_sync  <= {r_run_sync[SYNC_STAGES-2:0], i_run_sw};
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], i_step_btn};
            // Edge detect runs in every state, so edges arriving outside HALT are dropped.
            r_step_s_d  <= w_step_s;
            r_chk_valid <= 1'b0;
            r_chk_err   <= 1'b0;

            if (w_cpu_clk_en) begin
                r_inst_cnt <= r_inst_cnt + CNT_W'(1);
            end

            case (r_state)
                S_HALT: begin
                    r_rd_cnt <= '0;
                    if (chk_if.chk_req) begin
                        r_chk_addr <= chk_if.chk_sel;
                    end else if (w_run_s || w_step_rise) begin
                        r_bp_hit  <= 1'b0;
                        r_bp_skip <= w_pc_match;
                    end
                end
                S_RUN: begin
                    if (chk_if.chk_req) begin
                        r_chk_err <= 1'b1;
                    end
                    if (w_run_s && w_bp_stop) begin
                        r_bp_hit <= 1'b1;
                    end
                    if (w_cpu_clk_en) begin
                        r_bp_skip <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (chk_if.chk_req) begin
                        r_chk_err <= 1'b1;
                    end
                    r_bp_skip <= 1'b0;
                end
                S_READ: begin
                    r_rd_cnt <= r_rd_cnt + RD_W'(1);
                    if (w_read_done) begin
                        r_chk_data  <= i_cpu_check_data;
                        r_chk_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cpu_check_addr = r_chk_addr;
    assign o_cpu_clk_en     = w_cpu_clk_en;
    assign o_halted         = (r_state == S_HALT) || (r_state == S_READ);
    assign o_bp_hit         = r_bp_hit;
    assign o_inst_cnt       = r_inst_cnt;
    assign o_disp_next_pc   = i_next_pc;
    assign chk_if.chk_data  = r_chk_data;
    assign chk_if.chk_valid = r_chk_valid;
    assign chk_if.chk_err   = r_chk_err;

endmodule

// File: tb/tb_pdu_debug_ctrl.sv
// tb/tb_pdu_debug_ctrl.sv - self-checking bench for pdu_debug_ctrl with a CPU stub and scoreboard
module tb_pdu_debug_ctrl;
    localparam int SYNC_STAGES = 2;
    localparam int CHK_WAIT    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic        load_pc;
    logic [31:0] load_val;

    logic [31:0] cpu_check_addr, cpu_check_addr4;
    logic [31:0] cpu_check_data, cpu_check_data4;
    logic        cpu_clk_en, cpu_clk_en4;
    logic        halted, halted4;
    logic        bp_hit, bp_hit4;
    logic [31:0] inst_cnt;
    logic [3:0]  inst_cnt4;
    logic [31:0] disp_next_pc, disp_next_pc4;

    int n_checks = 0;
    int n_fail   = 0;
    int en_total = 0;

    pdu_debug_ctrl_if ifm ();
    pdu_debug_ctrl_if if4 ();

    always #5 clk = ~clk;

    // The CPU stub: the debug word for a selector is a fixed function of it.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h5) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    assign cpu_check_data  = word_at(cpu_check_addr);
    assign cpu_check_data4 = word_at(cpu_check_addr4);
    assign next_pc         = cur_pc + 32'd4;
    assign if4.chk_req     = ifm.chk_req;
    assign if4.chk_sel     = ifm.chk_sel;

    // CPU stub: PC advances by one word on every enabled clock.
    always @(posedge clk) begin
        if (load_pc) cur_pc <= load_val;
        else if (cpu_clk_en) cur_pc <= cur_pc + 32'd4;
    end

    // Scoreboard: count of executed instructions observed on the clock-enable.
    always @(negedge clk) begin
        if (rst) en_total = 0;
        else if (cpu_clk_en) en_total = en_total + 1;
    end

    pdu_debug_ctrl #(.SYNC_STAGES(SYNC_STAGES), .CHK_WAIT(CHK_WAIT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_run_sw(run_sw), .i_step_btn(step_btn), .i_bp_en(bp_en),
        .i_bp_addr(bp_addr), .i_current_pc(cur_pc), .i_next_pc(next_pc),
        .i_cpu_check_data(cpu_check_data), .chk_if(ifm), .o_cpu_check_addr(cpu_check_addr),
        .o_cpu_clk_en(cpu_clk_en), .o_halted(halted), .o_bp_hit(bp_hit),
        .o_inst_cnt(inst_cnt), .o_disp_next_pc(disp_next_pc)
    );

    pdu_debug_ctrl #(.SYNC_STAGES(SYNC_STAGES), .CHK_WAIT(CHK_WAIT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .i_run_sw(run_sw), .i_step_btn(step_btn), .i_bp_en(bp_en),
        .i_bp_addr(bp_addr), .i_current_pc(cur_pc), .i_next_pc(next_pc),
        .i_cpu_check_data(cpu_check_data4), .chk_if(if4), .o_cpu_check_addr(cpu_check_addr4),
        .o_cpu_clk_en(cpu_clk_en4), .o_halted(halted4), .o_bp_hit(bp_hit4),
        .o_inst_cnt(inst_cnt4), .o_disp_next_pc(disp_next_pc4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        load_val = v;
        load_pc  = 1'b1;
        tick();
        load_pc  = 1'b0;
    endtask

    task automatic do_step(input bit first);
        bit seen = 0;
        step_btn = 1'b1;
        for (int n = 1; n <= SYNC_STAGES + 2; n++) begin
            tick();
            if (cpu_clk_en) begin
                seen = 1;
                break;
            end
        end
        if (first || !seen) check("step_latency", seen, 1);
        tick();
        if (first || cpu_clk_en) check("step_one_cycle", cpu_clk_en, 0);
        step_btn = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        if (first) begin
            check("step_inst_cnt", inst_cnt, 1);
            check("step_halted", halted, 1);
        end
    endtask

    task automatic run_to_bp(input logic [31:0] base, input int n);
        int  start;
        bit  seen = 0;
        set_pc(base);
        bp_en   = 1'b1;
        bp_addr = base + 32'(4 * n);
        start   = en_total;
        run_sw  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bp_hit) begin
                seen = 1;
                break;
            end
        end
        check("bp_reached", seen, 1);
        check("bp_enables", en_total - start, n);
        check("bp_pc", cur_pc, bp_addr);
        check("bp_halted", halted, 1);
        check("bp_inst_cnt", inst_cnt, en_total);
        // run_sw still high: execution resumes and executes the breakpoint instruction once.
        tick();
        check("resume_bp_hit_clr", bp_hit, 0);
        check("resume_skip_exec", cpu_clk_en, 1);
        tick();
        check("resume_pc_past_bp", cur_pc, bp_addr + 32'd4);
        run_sw = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (halted) begin
                seen = 1;
                break;
            end
        end
        check("run_off_halts", seen, 1);
        check("cnt4_wrap", inst_cnt4, en_total % 16);
    endtask

    task automatic do_read(input logic [31:0] sel);
        int n = 0;
        ifm.chk_sel = sel;
        ifm.chk_req = 1'b1;
        tick();
        ifm.chk_req = 1'b0;
        check("read_addr", cpu_check_addr, sel);
        check("read_halted", halted, 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            n++;
            if (ifm.chk_valid) break;
        end
        check("read_latency", n, CHK_WAIT + 1);
        check("read_data", ifm.chk_data, word_at(sel));
        tick();
        check("read_valid_pulse", ifm.chk_valid, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev_data;
        int          halt_cnt;
        bit          seen;

        rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0; bp_addr = '0;
        ifm.chk_req = 1'b0; ifm.chk_sel = '0; load_pc = 1'b1; load_val = '0;
        repeat (3) tick();
        load_pc = 1'b0;
        rst = 1'b0;
        tick();

        check("rst_clk_en", cpu_clk_en, 0);
        check("rst_halted", halted, 1);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_inst_cnt", inst_cnt, 0);
        check("rst_chk_valid", ifm.chk_valid, 0);
        check("rst_chk_err", ifm.chk_err, 0);
        check("rst_chk_data", ifm.chk_data, 0);
        check("rst_check_addr", cpu_check_addr, 0);
        check("disp_next_pc", disp_next_pc, next_pc);

        for (int i = 0; i < 17; i++) do_step(i == 0);
        check("steps_total", inst_cnt, 17);
        check("steps_scoreboard", inst_cnt, en_total);
        check("steps_cnt4_wrap", inst_cnt4, 1);

        run_to_bp(32'h3000, 4);
        for (int i = 0; i < 3; i++)
            run_to_bp($urandom & 32'h0FFF_FFF0, int'($urandom_range(1, 12)));

        do_read(32'h5);
        for (int i = 0; i < 3; i++) do_read($urandom);

        // Request while running is rejected; a step edge during RUN is not queued.
        bp_en  = 1'b0;
        run_sw = 1'b1;
        seen   = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cpu_clk_en) begin
                seen = 1;
                break;
            end
        end
        check("run_started", seen, 1);
        prev_data   = ifm.chk_data;
        ifm.chk_sel = $urandom;
        ifm.chk_req = 1'b1;
        tick();
        ifm.chk_req = 1'b0;
        check("err_pulse", ifm.chk_err, 1);
        check("err_no_valid", ifm.chk_valid, 0);
        check("err_data_kept", ifm.chk_data, prev_data);
        check("err_still_running", cpu_clk_en, 1);
        tick();
        check("err_pulse_end", ifm.chk_err, 0);
        step_btn = 1'b1;
        repeat (6) tick();
        step_btn = 1'b0;
        run_sw   = 1'b0;
        repeat (SYNC_STAGES + 3) tick();
        check("run_off_halted", halted, 1);
        halt_cnt = en_total;
        repeat (8) tick();
        check("step_not_queued", en_total, halt_cnt);
        check("final_scoreboard", inst_cnt, en_total);

        // Reset in the middle of a read: no chk_valid, everything back to reset values.
        ifm.chk_sel = 32'h1234_5678;
        ifm.chk_req = 1'b1;
        tick();
        ifm.chk_req = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_read_addr", cpu_check_addr, 0);
        check("rst_read_halted", halted, 1);
        tick();
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ifm.chk_valid) seen = 1;
        end
        check("rst_read_no_valid", seen, 0);
        check("rst_read_inst_cnt", inst_cnt, 0);
        check("rst_read_addr_after", cpu_check_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
